// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives the shared-memory datapath control lines.
module mips_multicycle_ctrl #(
  parameter int ALUOP_W  = 2,
  parameter int MEM_WAIT = 1,
  parameter int TRAP_EN  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               branch_gtz,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         immsel,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_J     = 6'b000010;

  // With a 2-bit aluop every extension op collapses onto code 11
  localparam logic [ALUOP_W-1:0] AO_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AO_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AO_FN  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AO_XOR = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AO_LUI =
    ALUOP_W'((ALUOP_W == 3) ? 4 : 3);
  localparam logic [ALUOP_W-1:0] AO_LI  =
    ALUOP_W'((ALUOP_W == 3) ? 5 : 3);
  localparam logic [ALUOP_W-1:0] AO_GTZ =
    ALUOP_W'((ALUOP_W == 3) ? 6 : 3);

  state_t r_state;
  state_t w_next;
  logic   w_ready;
  logic   w_memwrite;
  logic   w_irwrite;
  logic   w_pcwrite;
  logic   w_branch;
  logic   w_bgtz;
  logic   w_regwrite;
  logic   w_illegal;

  assign w_ready = (MEM_WAIT == 0) | mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_bgtz     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    immsel     = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    pcsrc      = 2'b00;
    aluop      = AO_ADD;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
        w_next    = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:       w_next = S_RTYPEEX;
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_BEQ,
          OP_BGTZ:        w_next = S_BRANCH;
          OP_ADDI, OP_XORI,
          OP_LUI, OP_LI:  w_next = S_IMMEX;
          OP_J:           w_next = S_JUMP;
          default: begin
            if (TRAP_EN != 0) begin
              w_next = S_TRAP;
            end else begin
              w_next    = S_FETCH;
              w_illegal = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = w_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = AO_FN;
        w_next  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_IMMWB;
        case (op)
          OP_XORI: begin
            immsel = 2'b01;
            aluop  = AO_XOR;
          end
          OP_LUI: begin
            immsel = 2'b10;
            aluop  = AO_LUI;
          end
          OP_LI:   aluop = AO_LI;
          default: aluop = AO_ADD;
        endcase
      end
      S_IMMWB: w_regwrite = 1'b1;
      S_BRANCH: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        if (op == OP_BGTZ) begin
          w_bgtz = 1'b1;
          aluop  = AO_GTZ;
        end else begin
          w_branch = 1'b1;
          aluop    = AO_SUB;
        end
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables and the trap flag must drop the instant reset asserts
  assign memwrite   = w_memwrite & reset_n;
  assign irwrite    = w_irwrite  & reset_n;
  assign pcwrite    = w_pcwrite  & reset_n;
  assign branch     = w_branch   & reset_n;
  assign branch_gtz = w_bgtz     & reset_n;
  assign regwrite   = w_regwrite & reset_n;
  assign illegal_op = w_illegal  & reset_n;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: three parameterisations
// (2-bit aluop, 3-bit aluop, no-wait/no-trap) driven in lockstep.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  logic iord_a, mw_a, ir_a, pw_a, br_a, bg_a, asa_a;
  logic rd_a, m2r_a, rw_a, ill_a;
  logic [1:0] asb_a, imm_a, pcs_a, ao_a;
  logic [3:0] st_a;
  logic iord_b, mw_b, ir_b, pw_b, br_b, bg_b, asa_b;
  logic rd_b, m2r_b, rw_b, ill_b;
  logic [1:0] asb_b, imm_b, pcs_b;
  logic [2:0] ao_b;
  logic [3:0] st_b;
  logic iord_c, mw_c, ir_c, pw_c, br_c, bg_c, asa_c;
  logic rd_c, m2r_c, rw_c, ill_c;
  logic [1:0] asb_c, imm_c, pcs_c, ao_c;
  logic [3:0] st_c;
  logic [15:0] ctl_a, ctl_b, ctl_c;

  assign ctl_a = {iord_a, mw_a, ir_a, pw_a, br_a, bg_a, asa_a,
                  asb_a, imm_a, rd_a, m2r_a, rw_a, pcs_a};
  assign ctl_b = {iord_b, mw_b, ir_b, pw_b, br_b, bg_b, asa_b,
                  asb_b, imm_b, rd_b, m2r_b, rw_b, pcs_b};
  assign ctl_c = {iord_c, mw_c, ir_c, pw_c, br_c, bg_c, asa_c,
                  asb_c, imm_c, rd_c, m2r_c, rw_c, pcs_c};

  // {iord,memwrite,irwrite,pcwrite,branch,bgtz,alusrca,alusrcb,immsel,regdst,memtoreg,regwrite,pcsrc}
  localparam logic [15:0] C_FETCH = 16'b0_0_1_1_0_0_0_01_00_0_0_0_00;
  localparam logic [15:0] C_FWAIT = 16'b0_0_0_0_0_0_0_01_00_0_0_0_00;
  localparam logic [15:0] C_DEC   = 16'b0_0_0_0_0_0_0_11_00_0_0_0_00;
  localparam logic [15:0] C_MADR  = 16'b0_0_0_0_0_0_1_10_00_0_0_0_00;
  localparam logic [15:0] C_MRD   = 16'b1_0_0_0_0_0_0_00_00_0_0_0_00;
  localparam logic [15:0] C_MWB   = 16'b0_0_0_0_0_0_0_00_00_0_1_1_00;
  localparam logic [15:0] C_MWR   = 16'b1_1_0_0_0_0_0_00_00_0_0_0_00;
  localparam logic [15:0] C_REX   = 16'b0_0_0_0_0_0_1_00_00_0_0_0_00;
  localparam logic [15:0] C_RWB   = 16'b0_0_0_0_0_0_0_00_00_1_0_1_00;
  localparam logic [15:0] C_IEX_S = 16'b0_0_0_0_0_0_1_10_00_0_0_0_00;
  localparam logic [15:0] C_IEX_Z = 16'b0_0_0_0_0_0_1_10_01_0_0_0_00;
  localparam logic [15:0] C_IEX_U = 16'b0_0_0_0_0_0_1_10_10_0_0_0_00;
  localparam logic [15:0] C_IWB   = 16'b0_0_0_0_0_0_0_00_00_0_0_1_00;
  localparam logic [15:0] C_BEQ   = 16'b0_0_0_0_1_0_1_00_00_0_0_0_01;
  localparam logic [15:0] C_BGTZ  = 16'b0_0_0_0_0_1_1_00_00_0_0_0_01;
  localparam logic [15:0] C_JMP   = 16'b0_0_0_1_0_0_0_00_00_0_0_0_10;

  mips_multicycle_ctrl #(.ALUOP_W(2), .MEM_WAIT(1), .TRAP_EN(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iord(iord_a), .memwrite(mw_a), .irwrite(ir_a), .pcwrite(pw_a),
    .branch(br_a), .branch_gtz(bg_a), .alusrca(asa_a), .alusrcb(asb_a),
    .immsel(imm_a), .regdst(rd_a), .memtoreg(m2r_a), .regwrite(rw_a),
    .pcsrc(pcs_a), .aluop(ao_a), .illegal_op(ill_a), .state_o(st_a));

  mips_multicycle_ctrl #(.ALUOP_W(3), .MEM_WAIT(1), .TRAP_EN(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iord(iord_b), .memwrite(mw_b), .irwrite(ir_b), .pcwrite(pw_b),
    .branch(br_b), .branch_gtz(bg_b), .alusrca(asa_b), .alusrcb(asb_b),
    .immsel(imm_b), .regdst(rd_b), .memtoreg(m2r_b), .regwrite(rw_b),
    .pcsrc(pcs_b), .aluop(ao_b), .illegal_op(ill_b), .state_o(st_b));

  mips_multicycle_ctrl #(.ALUOP_W(2), .MEM_WAIT(0), .TRAP_EN(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iord(iord_c), .memwrite(mw_c), .irwrite(ir_c), .pcwrite(pw_c),
    .branch(br_c), .branch_gtz(bg_c), .alusrca(asa_c), .alusrcb(asb_c),
    .immsel(imm_c), .regdst(rd_c), .memtoreg(m2r_c), .regwrite(rw_c),
    .pcsrc(pcs_c), .aluop(ao_c), .illegal_op(ill_c), .state_o(st_c));

  // Called at a negedge; returns at the next negedge with reset released
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    op = 6'd0;
    #2;
    total++;
    if (st_a !== 4'd0 || ctl_a !== C_FWAIT || ill_a !== 1'b0 ||
        ao_a !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold: st=%0d ctl=%h ill=%b want st=0 ctl=%h ill=0",
               st_a, ctl_a, ill_a, C_FWAIT);
    end
    @(negedge clk);
    total++;
    if (st_b !== 4'd0 || ctl_b !== C_FWAIT || st_c !== 4'd0 ||
        ctl_c !== C_FWAIT) begin
      bad++;
      $display("FAIL reset_edge: st_b=%0d ctl_b=%h ctl_c=%h want 0 %h",
               st_b, ctl_b, ctl_c, C_FWAIT);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (st_a !== 4'd0 || ctl_a !== C_FETCH) begin
      bad++;
      $display("FAIL reset_release: st=%0d ctl=%h want st=0 ctl=%h",
               st_a, ctl_a, C_FETCH);
    end
    @(negedge clk);
  endtask

  task automatic test_lw();
    logic [3:0]  st [6];
    logic [15:0] cv [6];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    cv = '{C_FETCH, C_DEC, C_MADR, C_MRD, C_MWB, C_FETCH};
    do_reset();
    op = 6'b100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (st_a !== st[i] || ctl_a !== cv[i] || ao_a !== 2'b00 ||
          st_b !== st[i] || ctl_b !== cv[i] || ao_b !== 3'b000 ||
          st_c !== st[i] || ctl_c !== cv[i]) begin
        bad++;
        $display("FAIL lw[%0d]: st=%0d/%0d/%0d ctl=%h ao=%h want st=%0d ctl=%h",
                 i, st_a, st_b, st_c, ctl_a, ao_a, st[i], cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    op = 6'b000000;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (st_a !== 4'd0 || ctl_a !== C_FWAIT || st_b !== 4'd0) begin
        bad++;
        $display("FAIL fetch_wait[%0d]: st=%0d ctl=%h want st=0 ctl=%h",
                 i, st_a, ctl_a, C_FWAIT);
      end
      total++;
      if (i == 0 && (st_c !== 4'd0 || ctl_c !== C_FETCH)) begin
        bad++;
        $display("FAIL nowait_fetch: st=%0d ctl=%h want st=0 ctl=%h",
                 st_c, ctl_c, C_FETCH);
      end else if (i == 1 && st_c !== 4'd1) begin
        bad++;
        $display("FAIL nowait_decode: st=%0d want 1", st_c);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (st_a !== 4'd0 || ctl_a !== C_FETCH) begin
      bad++;
      $display("FAIL fetch_go: st=%0d ctl=%h want st=0 ctl=%h",
               st_a, ctl_a, C_FETCH);
    end
    @(negedge clk);
    #1;
    total++;
    if (st_a !== 4'd1 || ctl_a !== C_DEC) begin
      bad++;
      $display("FAIL rt_decode: st=%0d ctl=%h want st=1 ctl=%h",
               st_a, ctl_a, C_DEC);
    end
    @(negedge clk);
    #1;
    total++;
    if (st_a !== 4'd6 || ctl_a !== C_REX || ao_a !== 2'b10 ||
        ao_b !== 3'b010) begin
      bad++;
      $display("FAIL rt_ex: st=%0d ctl=%h ao=%h/%h want st=6 ctl=%h ao=2",
               st_a, ctl_a, ao_a, ao_b, C_REX);
    end
    @(negedge clk);
    #1;
    total++;
    if (st_a !== 4'd7 || ctl_a !== C_RWB) begin
      bad++;
      $display("FAIL rt_wb: st=%0d ctl=%h want st=7 ctl=%h",
               st_a, ctl_a, C_RWB);
    end
    @(negedge clk);
    #1;
    total++;
    if (st_a !== 4'd0) begin
      bad++;
      $display("FAIL rt_done: st=%0d want 0", st_a);
    end
    @(negedge clk);
  endtask

  task automatic test_imm();
    logic [5:0]  ops [4];
    logic [15:0] cv [4];
    logic [1:0]  aa [4];
    logic [2:0]  ab [4];
    ops = '{6'b001000, 6'b001110, 6'b001111, 6'b010001};
    cv  = '{C_IEX_S, C_IEX_Z, C_IEX_U, C_IEX_S};
    aa  = '{2'b00, 2'b11, 2'b11, 2'b11};
    ab  = '{3'b000, 3'b011, 3'b100, 3'b101};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      op = ops[k];
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (st_a !== 4'd1 || ctl_a !== C_DEC) begin
        bad++;
        $display("FAIL imm_dec[%0d]: st=%0d ctl=%h want st=1 ctl=%h",
                 k, st_a, ctl_a, C_DEC);
      end
      @(negedge clk);
      #1;
      total++;
      if (st_a !== 4'd9 || ctl_a !== cv[k] || ao_a !== aa[k] ||
          st_b !== 4'd9 || ctl_b !== cv[k] || ao_b !== ab[k]) begin
        bad++;
        $display("FAIL imm_ex[%0d]: st=%0d ctl=%h ao=%h/%h want st=9 ctl=%h ao=%h/%h",
                 k, st_a, ctl_a, ao_a, ao_b, cv[k], aa[k], ab[k]);
      end
      @(negedge clk);
      #1;
      total++;
      if (st_a !== 4'd10 || ctl_a !== C_IWB || ctl_b !== C_IWB) begin
        bad++;
        $display("FAIL imm_wb[%0d]: st=%0d ctl=%h want st=10 ctl=%h",
                 k, st_a, ctl_a, C_IWB);
      end
      @(negedge clk);
      #1;
      total++;
      if (st_a !== 4'd0 || st_b !== 4'd0) begin
        bad++;
        $display("FAIL imm_done[%0d]: st=%0d want 0", k, st_a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops [3];
    logic [3:0]  st [3];
    logic [15:0] cv [3];
    logic [1:0]  aa [3];
    logic [2:0]  ab [3];
    ops = '{6'b000100, 6'b000111, 6'b000010};
    st  = '{4'd8, 4'd8, 4'd11};
    cv  = '{C_BEQ, C_BGTZ, C_JMP};
    aa  = '{2'b01, 2'b11, 2'b00};
    ab  = '{3'b001, 3'b110, 3'b000};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      op = ops[k];
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (st_a !== st[k] || ctl_a !== cv[k] || ao_a !== aa[k] ||
          st_b !== st[k] || ctl_b !== cv[k] || ao_b !== ab[k]) begin
        bad++;
        $display("FAIL br[%0d]: st=%0d ctl=%h ao=%h/%h want st=%0d ctl=%h ao=%h/%h",
                 k, st_a, ctl_a, ao_a, ao_b, st[k], cv[k], aa[k], ab[k]);
      end
      @(negedge clk);
      #1;
      total++;
      if (st_a !== 4'd0 || ctl_a !== C_FETCH) begin
        bad++;
        $display("FAIL br_done[%0d]: st=%0d ctl=%h want st=0 ctl=%h",
                 k, st_a, ctl_a, C_FETCH);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_trap();
    do_reset();
    op = 6'b111111;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (st_a !== 4'd1 || ill_a !== 1'b0 || st_c !== 4'd1 ||
        ill_c !== 1'b1 || ctl_c !== C_DEC) begin
      bad++;
      $display("FAIL trap_dec: st=%0d ill=%b st_c=%0d ill_c=%b want 1 0 1 1",
               st_a, ill_a, st_c, ill_c);
    end
    @(negedge clk);
    #1;
    total++;
    if (st_c !== 4'd0 || ill_c !== 1'b0) begin
      bad++;
      $display("FAIL notrap_ret: st=%0d ill=%b want st=0 ill=0", st_c, ill_c);
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (st_a !== 4'd12 || ill_a !== 1'b1 || ctl_a !== 16'h0 ||
          st_b !== 4'd12 || ill_b !== 1'b1) begin
        bad++;
        $display("FAIL trap_hold[%0d]: st=%0d ill=%b ctl=%h want st=12 ill=1 ctl=0",
                 i, st_a, ill_a, ctl_a);
      end
      @(negedge clk);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (st_a !== 4'd0 || ill_a !== 1'b0 || ill_b !== 1'b0) begin
      bad++;
      $display("FAIL trap_reset: st=%0d ill=%b want st=0 ill=0", st_a, ill_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sw_reset();
    do_reset();
    op = 6'b101011;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (st_a !== 4'd2 || ctl_a !== C_MADR) begin
      bad++;
      $display("FAIL sw_adr: st=%0d ctl=%h want st=2 ctl=%h",
               st_a, ctl_a, C_MADR);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (st_a !== 4'd5 || ctl_a !== C_MWR || ctl_b !== C_MWR) begin
        bad++;
        $display("FAIL sw_wait[%0d]: st=%0d ctl=%h want st=5 ctl=%h",
                 i, st_a, ctl_a, C_MWR);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (st_a !== 4'd0 || mw_a !== 1'b0 || ctl_a !== C_FWAIT) begin
      bad++;
      $display("FAIL sw_reset: st=%0d mw=%b ctl=%h want st=0 mw=0 ctl=%h",
               st_a, mw_a, ctl_a, C_FWAIT);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (st_a !== 4'd0 || pw_a !== 1'b0) begin
      bad++;
      $display("FAIL sw_post_wait: st=%0d pcwrite=%b want st=0 pcwrite=0",
               st_a, pw_a);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    total++;
    if (st_a !== 4'd0 || pw_a !== 1'b1 || ir_a !== 1'b1) begin
      bad++;
      $display("FAIL sw_post_go: st=%0d pcwrite=%b want st=0 pcwrite=1",
               st_a, pw_a);
    end
    @(negedge clk);
    #1;
    total++;
    if (st_a !== 4'd1) begin
      bad++;
      $display("FAIL sw_post_dec: st=%0d want 1", st_a);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [12];
    logic [3:0]  st [12];
    logic [15:0] cv [12];
    ops = '{6'b101011, 6'b101011, 6'b101011, 6'b101011,
            6'b000010, 6'b000010, 6'b000010,
            6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    st  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd11,
            4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    cv  = '{C_FETCH, C_DEC, C_MADR, C_MWR, C_FETCH, C_DEC, C_JMP,
            C_FETCH, C_DEC, C_REX, C_RWB, C_FETCH};
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = ops[i];
      #1;
      total++;
      if (st_a !== st[i] || ctl_a !== cv[i] ||
          st_c !== st[i] || ctl_c !== cv[i]) begin
        bad++;
        $display("FAIL b2b[%0d]: st=%0d/%0d ctl=%h/%h want st=%0d ctl=%h",
                 i, st_a, st_c, ctl_a, ctl_c, st[i], cv[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lw();
    test_fetch_wait();
    test_imm();
    test_branch_jump();
    test_trap();
    test_sw_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
